piso_shift_tx: RTL

Parameterised parallel-in serial-out transmitter: the sending end of the serial bit stream our SIPO receiver consumes. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out MSB-first, one bit per clock. Output carries a per-bit valid and a frame-last marker. Back-to-back words stream with no idle gap, so a downstream SIPO sees a continuous bit train.

---
 rtl/piso_shift_tx.sv | 114 +++++++++++
 1 files changed

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: loads a WIDTH-bit word on a valid/ready
// handshake and shifts it out MSB-first. Optional macro PISO_PARITY_EN appends an even-parity bit.
module piso_shift_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last,
  output logic             dbg_state
);

  // Load handshake: a word is taken on a rising edge where load_valid && load_ready.
  // load_ready is high in IDLE and on the final frame bit, so frames chain without a gap.
`ifdef PISO_PARITY_EN
  localparam int N = WIDTH + 1;
`else
  localparam int N = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] PRE_LAST_IDX = CW'(N - 2);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             dv_q, dv_d;
  logic             last_q, last_d;
  logic             next_bit;
  logic             load_fire;

`ifdef PISO_PARITY_EN
  logic par_q, par_d;
  // Parity goes out once every data bit has left the shift register.
  assign next_bit = (cnt_q == CW'(WIDTH - 1)) ? par_q : sr_q[WIDTH-1];
`else
  assign next_bit = sr_q[WIDTH-1];
`endif

  assign load_ready = rst_n && ((state_q == IDLE) || (cnt_q == LAST_IDX));
  assign load_fire  = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dv_d    = dv_q;
    last_d  = last_q;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    if (load_fire) begin
      state_d = SHIFT;
      dout_d  = din[WIDTH-1];
      sr_d    = {din[WIDTH-2:0], 1'b0};
      cnt_d   = '0;
      dv_d    = 1'b1;
      last_d  = 1'b0;
`ifdef PISO_PARITY_EN
      par_d   = ^din;
`endif
    end else if (state_q == SHIFT) begin
      if (cnt_q == LAST_IDX) begin
        state_d = IDLE;
        dout_d  = 1'b0;
        dv_d    = 1'b0;
        last_d  = 1'b0;
      end else begin
        dout_d = next_bit;
        sr_d   = sr_q << 1;
        cnt_d  = cnt_q + 1'b1;
        last_d = (cnt_q == PRE_LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign last       = last_q;
  assign dbg_state  = (state_q == SHIFT);

endmodule
